// File: rtl/discrete_mapper.sv
// rtl/discrete_mapper.sv - CNROM/UxROM/GxROM/AxROM discrete mapper with M2-synchronised bank register capture
// Optional feature macro: DISCRETE_BUS_CONFLICT_EN (committed value = cpu data AND prg rom data)
module discrete_mapper #(
  parameter int ADDR_BITS     = 22,
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 mirroring,
  input  logic                 chr_ram,
  input  logic                 m2,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rw,
  input  logic [7:0]           cpu_data_in,
  input  logic [7:0]           prg_data_in,
  input  logic [13:0]          ppu_addr,
  input  logic                 ppu_rd,
  input  logic                 ppu_wr,
  output logic [ADDR_BITS-1:0] prg_addr,
  output logic                 prg_oe,
  output logic [ADDR_BITS-1:0] chr_addr,
  output logic                 chr_ce,
  output logic                 ciram_ce,
  output logic                 chr_oe,
  output logic                 chr_we,
  output logic                 ciram_a10,
  output logic [7:0]           bank_reg
);

  localparam logic [1:0] MODE_CNROM = 2'd0;
  localparam logic [1:0] MODE_UXROM = 2'd1;
  localparam logic [1:0] MODE_GXROM = 2'd2;
  localparam logic [1:0] MODE_AXROM = 2'd3;

  // Bank field masks; UxROM's fixed upper window uses the PRG mask as "last bank".
  localparam logic [7:0] PRG_MASK = 8'((1 << PRG_BANK_BITS) - 1);
  localparam logic [7:0] CHR_MASK = 8'((1 << CHR_BANK_BITS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] bank_q, bank_d;
  logic       wr_flag_q, wr_flag_d;
  logic [7:0] data_hold_q, data_hold_d;
  logic [7:0] commit_val;

  logic       m2_meta_q, m2_s_q, m2_s_dly_q;
  logic [1:0] mode_q;
  logic       m2_fall;
  logic       mode_change;

`ifdef DISCRETE_BUS_CONFLICT_EN
  logic [7:0] prg_hold_q, prg_hold_d;
  // Bus conflict: the ROM drives the data bus at the same time as the CPU.
  assign commit_val = data_hold_q & prg_hold_q;
`else
  assign commit_val = data_hold_q;
`endif

  assign m2_fall     = m2_s_dly_q && !m2_s_q;
  assign mode_change = (mode != mode_q);

  // M2 two-flop synchroniser, edge-detect delay flop and mode tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2_meta_q  <= 1'b0;
      m2_s_q     <= 1'b0;
      m2_s_dly_q <= 1'b0;
      mode_q     <= mode;
    end else begin
      m2_meta_q  <= m2;
      m2_s_q     <= m2_meta_q;
      m2_s_dly_q <= m2_s_q;
      mode_q     <= mode;
    end
  end

  // Capture FSM state, bank register and hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bank_q      <= 8'h00;
      wr_flag_q   <= 1'b0;
      data_hold_q <= 8'h00;
`ifdef DISCRETE_BUS_CONFLICT_EN
      prg_hold_q  <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      wr_flag_q   <= wr_flag_d;
      data_hold_q <= data_hold_d;
`ifdef DISCRETE_BUS_CONFLICT_EN
      prg_hold_q  <= prg_hold_d;
`endif
    end
  end

  // Capture FSM next state: enter on a high-M2 store to $8000+, resample while high, commit after the fall.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    wr_flag_d   = wr_flag_q;
    data_hold_d = data_hold_q;
`ifdef DISCRETE_BUS_CONFLICT_EN
    prg_hold_d  = prg_hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m2_s_q && cpu_addr[15] && !cpu_rw) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (m2_s_q) begin
          wr_flag_d   = cpu_addr[15] && !cpu_rw;
          data_hold_d = cpu_data_in;
`ifdef DISCRETE_BUS_CONFLICT_EN
          prg_hold_d  = prg_data_in;
`endif
        end
        if (m2_fall) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (wr_flag_q) begin
          bank_d = commit_val;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Switching board type invalidates the old bank and any store in flight.
    if (mode_change) begin
      bank_d  = 8'h00;
      state_d = ST_IDLE;
    end
  end

  // Per-board PRG/CHR address maps, combinational from the bank register.
  always_comb begin
    logic [7:0] prg_bank;
    logic [7:0] chr_bank;
    prg_bank = 8'h00;
    chr_bank = 8'h00;
    prg_addr = ADDR_BITS'(cpu_addr[14:0]);
    chr_addr = ADDR_BITS'(ppu_addr[12:0]);
    case (mode)
      MODE_CNROM: begin
        chr_bank = bank_q & CHR_MASK;
        prg_addr = ADDR_BITS'(cpu_addr[14:0]);
        chr_addr = (ADDR_BITS'(chr_bank) << 13) | ADDR_BITS'(ppu_addr[12:0]);
      end
      MODE_UXROM: begin
        prg_bank = cpu_addr[14] ? PRG_MASK : (bank_q & PRG_MASK);
        prg_addr = (ADDR_BITS'(prg_bank) << 14) | ADDR_BITS'(cpu_addr[13:0]);
        chr_addr = ADDR_BITS'(ppu_addr[12:0]);
      end
      MODE_GXROM: begin
        prg_bank = {6'b0, bank_q[5:4]} & PRG_MASK;
        chr_bank = {6'b0, bank_q[1:0]} & CHR_MASK;
        prg_addr = (ADDR_BITS'(prg_bank) << 15) | ADDR_BITS'(cpu_addr[14:0]);
        chr_addr = (ADDR_BITS'(chr_bank) << 13) | ADDR_BITS'(ppu_addr[12:0]);
      end
      MODE_AXROM: begin
        prg_bank = {5'b0, bank_q[2:0]} & PRG_MASK;
        prg_addr = (ADDR_BITS'(prg_bank) << 15) | ADDR_BITS'(cpu_addr[14:0]);
        chr_addr = ADDR_BITS'(ppu_addr[12:0]);
      end
      default: begin
        prg_addr = ADDR_BITS'(cpu_addr[14:0]);
        chr_addr = ADDR_BITS'(ppu_addr[12:0]);
      end
    endcase
  end

  // AxROM selects a single screen from the register; other boards use fixed mirroring.
  assign ciram_a10 = (mode == MODE_AXROM) ? bank_q[4]
                                          : (mirroring ? ppu_addr[10] : ppu_addr[11]);

  assign prg_oe   = cpu_addr[15] && cpu_rw;
  assign chr_ce   = !ppu_addr[13];
  assign ciram_ce = !ppu_addr[13];
  assign chr_oe   = !ppu_rd;
  assign chr_we   = chr_ram && !ppu_wr;
  assign bank_reg = bank_q;

endmodule

// File: tb/tb_discrete_mapper.sv
// tb/tb_discrete_mapper.sv - scoreboard bench for discrete_mapper with directed vectors
module tb_discrete_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        mirroring;
  logic        chr_ram;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data_in;
  logic [7:0]  prg_data_in;
  logic [13:0] ppu_addr;
  logic        ppu_rd;
  logic        ppu_wr;
  logic [21:0] prg_addr;
  logic        prg_oe;
  logic [21:0] chr_addr;
  logic        chr_ce;
  logic        ciram_ce;
  logic        chr_oe;
  logic        chr_we;
  logic        ciram_a10;
  logic [7:0]  bank_reg;

  discrete_mapper #(
    .ADDR_BITS(22),
    .PRG_BANK_BITS(4),
    .CHR_BANK_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .mirroring(mirroring), .chr_ram(chr_ram),
    .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_data_in(cpu_data_in),
    .prg_data_in(prg_data_in), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_wr(ppu_wr),
    .prg_addr(prg_addr), .prg_oe(prg_oe), .chr_addr(chr_addr), .chr_ce(chr_ce),
    .ciram_ce(ciram_ce), .chr_oe(chr_oe), .chr_we(chr_we), .ciram_a10(ciram_a10),
    .bank_reg(bank_reg)
  );

  always #20 clk = ~clk;

  localparam int SEL_BANK  = 0;
  localparam int SEL_PRG   = 1;
  localparam int SEL_CHR   = 2;
  localparam int SEL_CIRAM = 3;
  localparam int SEL_PRGOE = 4;
  localparam int SEL_CHRCE = 5;
  localparam int SEL_CHRWE = 6;
  localparam int SEL_CHROE = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  event sb_ev;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

`ifdef DISCRETE_BUS_CONFLICT_EN
  localparam logic [7:0] CONFLICT_EXP = 8'h05;
  localparam logic [31:0] CONFLICT_CHR = 32'h0A123;
`else
  localparam logic [7:0] CONFLICT_EXP = 8'h0F;
  localparam logic [31:0] CONFLICT_CHR = 32'h1E123;
`endif

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      SEL_BANK:  return {24'b0, bank_reg};
      SEL_PRG:   return {10'b0, prg_addr};
      SEL_CHR:   return {10'b0, chr_addr};
      SEL_CIRAM: return {31'b0, ciram_a10};
      SEL_PRGOE: return {31'b0, prg_oe};
      SEL_CHRCE: return {31'b0, chr_ce & ciram_ce};
      SEL_CHRWE: return {31'b0, chr_we};
      SEL_CHROE: return {31'b0, chr_oe};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: whenever the scoreboard is handed an expectation, compare it with the DUT.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(sb_ev);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        act = dut_val(c.sel);
        checks++;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    #1;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb_q.push_back(c);
    -> sb_ev;
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor did not consume entry (pending %0d, required 0)", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic m2_high(input logic [15:0] a, input logic [7:0] d, input logic [7:0] p, input logic rw);
    @(negedge clk);
    cpu_addr    = a;
    cpu_rw      = rw;
    cpu_data_in = d;
    prg_data_in = p;
    m2          = 1'b1;
    repeat (6) @(negedge clk);
    m2 = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic [7:0] p);
    m2_high(a, d, p, 1'b0);
    repeat (5) @(negedge clk);
    cpu_rw = 1'b1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; mode = 2'd0; mirroring = 1'b1; chr_ram = 1'b0; m2 = 1'b0;
    cpu_addr = 16'h8010; cpu_rw = 1'b1; cpu_data_in = 8'h00; prg_data_in = 8'hFF;
    ppu_addr = 14'h0123; ppu_rd = 1'b1; ppu_wr = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    expect_val("reset_bank", SEL_BANK, 32'h00);
    expect_val("reset_cnrom_chr", SEL_CHR, 32'h0123);
    expect_val("cnrom_prg", SEL_PRG, 32'h0010);
    expect_val("prg_oe_read", SEL_PRGOE, 32'h1);

    @(negedge clk);
    expect_val("chr_ce_low_half", SEL_CHRCE, 32'h1);
    ppu_addr = 14'h2123;
    expect_val("chr_ce_nametable", SEL_CHRCE, 32'h0);
    ppu_addr = 14'h0123;

    // CNROM write $03 with latency check
    m2_high(16'h8000, 8'h03, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    expect_val("cnrom_chr_before_commit", SEL_CHR, 32'h0123);
    @(negedge clk);
    expect_val("cnrom_chr_after_commit", SEL_CHR, 32'h6123);
    expect_val("cnrom_bank", SEL_BANK, 32'h03);
    repeat (2) @(negedge clk);
    cpu_rw = 1'b1;

    // Stores below $8000 and reads at $8000 are ignored
    cpu_write(16'h6000, 8'h0A, 8'hFF);
    expect_val("write_6000_ignored", SEL_BANK, 32'h03);
    m2_high(16'h8000, 8'h0C, 8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    expect_val("read_8000_ignored", SEL_BANK, 32'h03);

    // UxROM
    set_mode(2'd1);
    expect_val("mode_change_clears", SEL_BANK, 32'h00);
    cpu_write(16'h8000, 8'h05, 8'hFF);
    cpu_addr = 16'h8010;
    expect_val("uxrom_prg_switch", SEL_PRG, 32'h14010);
    cpu_addr = 16'hC010;
    expect_val("uxrom_prg_fixed", SEL_PRG, 32'h3C010);
    ppu_addr = 14'h1234;
    expect_val("uxrom_chr", SEL_CHR, 32'h1234);
    @(negedge clk);
    mirroring = 1'b0; ppu_addr = 14'h0800;
    expect_val("horiz_mirror_hi", SEL_CIRAM, 32'h1);
    ppu_addr = 14'h0400;
    expect_val("horiz_mirror_lo", SEL_CIRAM, 32'h0);
    mirroring = 1'b1;
    expect_val("vert_mirror", SEL_CIRAM, 32'h1);

    // AxROM
    set_mode(2'd3);
    cpu_write(16'h8000, 8'h13, 8'hFF);
    cpu_addr = 16'h8000;
    expect_val("axrom_prg", SEL_PRG, 32'h18000);
    mirroring = 1'b0; ppu_addr = 14'h0000;
    expect_val("axrom_single_screen_a", SEL_CIRAM, 32'h1);
    mirroring = 1'b1;
    expect_val("axrom_single_screen_b", SEL_CIRAM, 32'h1);
    @(negedge clk);
    ppu_addr = 14'h1ABC;
    expect_val("axrom_chr", SEL_CHR, 32'h1ABC);
    chr_ram = 1'b1; ppu_wr = 1'b0; ppu_rd = 1'b0;
    expect_val("chr_we_ram", SEL_CHRWE, 32'h1);
    expect_val("chr_oe_rd", SEL_CHROE, 32'h1);
    @(negedge clk);
    chr_ram = 1'b0;
    expect_val("chr_we_rom", SEL_CHRWE, 32'h0);
    ppu_wr = 1'b1; ppu_rd = 1'b1;

    // Bus conflict behaviour
    set_mode(2'd0);
    cpu_write(16'h8000, 8'h0F, 8'h05);
    ppu_addr = 14'h0123;
    expect_val("conflict_bank", SEL_BANK, {24'b0, CONFLICT_EXP});
    expect_val("conflict_chr", SEL_CHR, CONFLICT_CHR);

    // Reset during CAPTURE abandons the write
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_rw = 1'b0; cpu_data_in = 8'h07; m2 = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m2 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    cpu_rw = 1'b1;
    repeat (5) @(negedge clk);
    expect_val("reset_mid_capture", SEL_BANK, 32'h00);

    // Mode change clears bank, then GxROM map
    cpu_write(16'h8000, 8'h21, 8'hFF);
    expect_val("bank_21", SEL_BANK, 32'h21);
    @(negedge clk);
    mode = 2'd2;
    expect_val("mode_change_same_cycle", SEL_BANK, 32'h21);
    @(negedge clk);
    expect_val("mode_change_next_clk", SEL_BANK, 32'h00);
    cpu_write(16'h8000, 8'h31, 8'hFF);
    cpu_addr = 16'h8000; ppu_addr = 14'h0000;
    expect_val("gxrom_prg", SEL_PRG, 32'h18000);
    expect_val("gxrom_chr", SEL_CHR, 32'h2000);

    // Back-to-back write overrides
    cpu_write(16'h8000, 8'h10, 8'hFF);
    cpu_write(16'hFFFF, 8'h02, 8'hFF);
    cpu_addr = 16'h8000; ppu_addr = 14'h0000;
    expect_val("b2b_bank", SEL_BANK, 32'h02);
    expect_val("b2b_gxrom_chr", SEL_CHR, 32'h4000);

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL watchdog: simulation time limit reached (done=%0d, required 1)", done);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule
